// File: rtl/fpflags_accum.sv
// fpflags_accum: sticky floating-point exception accumulator.
// Per-op flag words are buffered in a small FIFO. Each word drained from the
// FIFO is ORed into the sticky status and bumps a saturating event counter
// for every flag bit it has set. The interrupt is raised from the sticky bits
// that are enabled in irq_mask.
//
// Ports:
//   clk, reset_n          clock; asynchronous active-low reset
//   res_valid/res_ready   flag-word handshake (res_ready = not full, registered)
//   res_flags[3:0]        {inexact, underflow, overflow, invalid}
//   freeze                holds the FIFO drain (pushes continue until full)
//   csr_clr/csr_clr_mask  one-cycle clear of the selected sticky bits and counters
//   irq_mask[3:0]         interrupt enable per flag
//   cnt_sel[1:0]          selects which counter drives cnt_value
//   sticky[3:0]           accumulated sticky flags
//   cnt_value[CNT_W-1:0]  selected event counter
//   irq                   |(sticky & irq_mask)
//   busy                  FIFO non-empty
module fpflags_accum #(
  parameter int CNT_W = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [3:0]       res_flags,
  input  logic             freeze,
  input  logic             csr_clr,
  input  logic [3:0]       csr_clr_mask,
  input  logic [3:0]       irq_mask,
  input  logic [1:0]       cnt_sel,
  output logic [3:0]       sticky,
  output logic [CNT_W-1:0] cnt_value,
  output logic             irq,
  output logic             busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [3:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             ready_q;
  logic [3:0]       sticky_q;
  logic [CNT_W-1:0] cnt [4];

  logic             full;
  logic             push;
  logic             pop;
  logic [3:0]       set_bits;
  logic [3:0]       clr_bits;

  // Handshake: ready depends only on registered state, never on res_valid.
  assign full      = (count == FULL_CNT);
  assign res_ready = ready_q & ~full;
  assign push      = res_valid & res_ready;
  assign pop       = (count != '0) & ~freeze;

  // NOTE: every signal written in always_comb gets a default first so no
  // path leaves it unassigned, which is what would infer a latch.
  always_comb begin
    set_bits = 4'b0000;
    clr_bits = 4'b0000;
    if (pop)     set_bits = mem[rd_ptr];
    if (csr_clr) clr_bits = csr_clr_mask;
  end

  // NOTE: the storage array carries no reset; it is only ever read behind a
  // non-zero occupancy, so stale contents are never observed and the array
  // can map onto plain register-file cells.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= res_flags;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky bits and counters. A clear and a set landing on the same flag in
  // one cycle resolve in favour of the set: sticky stays 1, counter restarts
  // at 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sticky_q <= 4'b0000;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sticky_q <= (sticky_q & ~clr_bits) | set_bits;
      for (int i = 0; i < 4; i++) begin
        if (clr_bits[i])
          cnt[i] <= set_bits[i] ? CNT_W'(1) : '0;
        else if (set_bits[i] && (cnt[i] != CNT_MAX))
          cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  assign sticky    = sticky_q;
  assign cnt_value = cnt[cnt_sel];
  assign irq       = |(sticky_q & irq_mask);
  assign busy      = (count != '0);

endmodule

// File: tb/tb_fpflags_accum.sv
// Self-checking bench for fpflags_accum. A queue holds the flag words the
// bench has handed to the DUT; the model drains it the same cycle the DUT
// should, and the sticky/counter/irq/busy/ready outputs are compared after
// every clock edge, plus literal spot checks for the directed scenarios.
module tb_fpflags_accum;

  localparam int CNT_W = 8;
  localparam int DEPTH = 2;
  localparam int MAX   = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset_n;
  logic             res_valid;
  logic             res_ready;
  logic [3:0]       res_flags;
  logic             freeze;
  logic             csr_clr;
  logic [3:0]       csr_clr_mask;
  logic [3:0]       irq_mask;
  logic [1:0]       cnt_sel;
  logic [3:0]       sticky;
  logic [CNT_W-1:0] cnt_value;
  logic             irq;
  logic             busy;

  fpflags_accum #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_flags    (res_flags),
    .freeze       (freeze),
    .csr_clr      (csr_clr),
    .csr_clr_mask (csr_clr_mask),
    .irq_mask     (irq_mask),
    .cnt_sel      (cnt_sel),
    .sticky       (sticky),
    .cnt_value    (cnt_value),
    .irq          (irq),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Scoreboard / model state
  logic [3:0] q [$];
  logic [3:0] ms;
  int         mc [4];
  bit         m_run;
  int         accepted;
  int         tests;
  int         fails;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cnt_is(input int sel, input int exp, input string tag);
    cnt_sel = 2'(sel);
    #1;
    check(tag, 32'(cnt_value), exp);
  endtask

  task automatic model_reset();
    ms    = 4'b0000;
    for (int i = 0; i < 4; i++) mc[i] = 0;
    q.delete();
    m_run = 1'b0;
  endtask

  task automatic check_all();
    check("sticky", 32'(sticky), 32'(ms));
    check("busy", 32'(busy), 32'(q.size() != 0));
    check("irq", 32'(irq), 32'(|(ms & irq_mask)));
    check("res_ready", 32'(res_ready), 32'(m_run && (q.size() < DEPTH)));
    for (int s = 0; s < 4; s++) begin
      cnt_sel = 2'(s);
      #1;
      check($sformatf("cnt%0d", s), 32'(cnt_value), 32'(mc[s]));
    end
  endtask

  // One clock: predict from pre-edge inputs, let the edge happen, update the
  // model, compare, and return on the falling edge ready for new inputs.
  task automatic cycle();
    bit         do_pop;
    bit         do_push;
    logic [3:0] head;
    logic [3:0] clr;
    logic [3:0] flags;
    do_pop  = 1'b0;
    do_push = 1'b0;
    head    = 4'b0000;
    clr     = 4'b0000;
    flags   = res_flags;
    if (reset_n) begin
      do_pop  = (q.size() != 0) && !freeze;
      if (do_pop) head = q[0];
      do_push = res_valid && m_run && (q.size() < DEPTH);
      if (csr_clr) clr = csr_clr_mask;
    end
    @(posedge clk);
    #1;
    if (reset_n) begin
      for (int i = 0; i < 4; i++) begin
        if (clr[i]) begin
          ms[i] = 1'b0;
          mc[i] = 0;
        end
        if (head[i]) begin
          ms[i] = 1'b1;
          if (mc[i] < MAX) mc[i]++;
        end
      end
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back(flags);
        accepted++;
      end
      m_run = 1'b1;
    end
    check_all();
    @(negedge clk);
  endtask

  task automatic clear_all();
    csr_clr      = 1'b1;
    csr_clr_mask = 4'b1111;
    cycle();
    csr_clr      = 1'b0;
    csr_clr_mask = 4'b0000;
  endtask

  initial begin
    tests        = 0;
    fails        = 0;
    accepted     = 0;
    reset_n      = 1'b0;
    res_valid    = 1'b0;
    res_flags    = 4'b0000;
    freeze       = 1'b0;
    csr_clr      = 1'b0;
    csr_clr_mask = 4'b0000;
    irq_mask     = 4'b0000;
    cnt_sel      = 2'd0;
    model_reset();

    // Reset state, before and across edges with reset held
    #3;
    check_all();
    check("ready_in_reset", 32'(res_ready), 32'd0);
    cycle();
    cycle();
    reset_n = 1'b1;
    cycle();
    check("ready_after_release", 32'(res_ready), 32'd1);

    // Single word, two-edge latency to sticky/counter
    res_valid = 1'b1;
    res_flags = 4'b0001;
    cycle();
    res_valid = 1'b0;
    cycle();
    check("lat_sticky", 32'(sticky), 32'h1);
    check("lat_busy", 32'(busy), 32'd0);
    cnt_is(0, 1, "lat_cnt0");

    // Freeze fills the FIFO; third word waits until space frees
    clear_all();
    freeze    = 1'b1;
    res_valid = 1'b1;
    res_flags = 4'b0010;
    cycle();
    res_flags = 4'b0100;
    cycle();
    res_flags = 4'b1000;
    check("frz_ready_full", 32'(res_ready), 32'd0);
    check("frz_sticky_held", 32'(sticky), 32'h0);
    cycle();
    freeze = 1'b0;
    cycle();
    cycle();
    check("frz_sticky", 32'(sticky), 32'h6);
    res_valid = 1'b0;
    cycle();
    check("frz_third", 32'(sticky), 32'he);

    // Saturation: 2^CNT_W+3 words of 0001
    clear_all();
    accepted  = 0;
    res_valid = 1'b1;
    res_flags = 4'b0001;
    for (int n = 0; n < 2000 && accepted < MAX + 4; n++) cycle();
    check("sat_accepted", 32'(accepted), 32'(MAX + 4));
    res_valid = 1'b0;
    cycle();
    cycle();
    check("sat_sticky", 32'(sticky), 32'h1);
    cnt_is(0, MAX, "sat_cnt0");

    // Clear and pop on the same flag: set wins
    res_valid = 1'b1;
    res_flags = 4'b1111;
    cycle();
    res_valid = 1'b0;
    cycle();
    check("all_sticky", 32'(sticky), 32'hf);
    res_valid = 1'b1;
    res_flags = 4'b0001;
    cycle();
    res_valid    = 1'b0;
    csr_clr      = 1'b1;
    csr_clr_mask = 4'b0011;
    cycle();
    csr_clr      = 1'b0;
    csr_clr_mask = 4'b0000;
    check("clr_pop_sticky", 32'(sticky), 32'hd);
    cnt_is(0, 1, "clr_pop_cnt0");
    cnt_is(1, 0, "clr_pop_cnt1");

    // Clear with empty mask changes nothing
    csr_clr = 1'b1;
    cycle();
    csr_clr = 1'b0;
    check("clr_mask0", 32'(sticky), 32'hd);

    // Zero word only moves occupancy
    res_valid = 1'b1;
    res_flags = 4'b0000;
    cycle();
    res_valid = 1'b0;
    cycle();
    check("zero_word", 32'(sticky), 32'hd);

    // Interrupt from an enabled flag, then cleared
    clear_all();
    irq_mask  = 4'b0100;
    res_valid = 1'b1;
    res_flags = 4'b0100;
    cycle();
    res_valid = 1'b0;
    cycle();
    check("irq_set", 32'(irq), 32'd1);
    csr_clr      = 1'b1;
    csr_clr_mask = 4'b0100;
    cycle();
    csr_clr      = 1'b0;
    csr_clr_mask = 4'b0000;
    check("irq_clr", 32'(irq), 32'd0);

    // Reset mid-operation discards buffered words
    freeze    = 1'b1;
    res_valid = 1'b1;
    res_flags = 4'b0011;
    cycle();
    res_flags = 4'b0101;
    cycle();
    res_valid = 1'b0;
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    cycle();
    reset_n = 1'b1;
    freeze  = 1'b0;
    cycle();
    cycle();
    cycle();
    check("post_rst_sticky", 32'(sticky), 32'h0);
    check("post_rst_busy", 32'(busy), 32'd0);
    cnt_is(0, 0, "post_rst_cnt0");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
